// File: rtl/ad9643_capture_framer.sv
// ad9643_capture_framer
// Qualifies AD9643 A/B sample pairs with data_en and packs each pair into a
// 32-bit word. Words are grouped into FRAME_LEN-word frames marked with tlast
// and buffered in a FIFO that drives an AXI4-Stream master. A frame is admitted
// only if the FIFO has room for all of it; otherwise the whole frame is skipped.
// Optional build macro: ADC_TEST_PATTERN_EN replaces the ADC data with a
// 14-bit ramp (A = r, B = ~r).
module ad9643_capture_framer #(
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 2048,
    parameter int OFFSET_BIN = 0
) (
    input  logic        adc_clk,
    input  logic        adc_rst,
    input  logic        data_en,
    input  logic        adc_valid,
    input  logic [13:0] adc_data_a,
    input  logic [13:0] adc_data_b,
    input  logic        adc_or_a,
    input  logic        adc_or_b,
    output logic        adc_or_state,
    output logic        ovf_sticky,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [AW+1:0] ADMIT_MAX = (AW+2)'(FIFO_DEPTH - FRAME_LEN);
    localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_LEN - 1);
    localparam logic [13:0]   MSB_FLIP  = (OFFSET_BIN != 0) ? 14'h2000 : 14'h0000;

    typedef enum logic [1:0] {IDLE, CAPTURE, SKIP} state_t;

    // input register
    logic        in_vld_q, in_vld_d, in_en_q, in_en_d, in_or_q, in_or_d;
    logic [13:0] in_a_q, in_a_d, in_b_q, in_b_d;
    // framing FSM
    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        wr_en, wr_last, admit;
    logic [13:0] smp_a, smp_b;
    logic [32:0] wr_word;
    // FIFO + output register
    logic [32:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mem_cnt;
    logic [AW+1:0] occ;
    logic        rd_en, out_vld_q, out_vld_d;
    logic [32:0] out_word_q;
    // overrange status
    logic        or_q, or_d, en_prev_q, en_prev_d;

    // capture the deserializer outputs and the enable level into one aligned stage
    always_comb begin
        in_vld_d = adc_valid;
        in_en_d  = data_en;
        in_or_d  = adc_or_a | adc_or_b;
        in_a_d   = adc_data_a;
        in_b_d   = adc_data_b;
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            in_vld_q <= 1'b0;
            in_en_q  <= 1'b0;
            in_or_q  <= 1'b0;
            in_a_q   <= '0;
            in_b_q   <= '0;
        end else begin
            in_vld_q <= in_vld_d;
            in_en_q  <= in_en_d;
            in_or_q  <= in_or_d;
            in_a_q   <= in_a_d;
            in_b_q   <= in_b_d;
        end
    end

    // occupancy counts the output register too, so admission sees every stored word
    always_comb begin
        mem_cnt  = wr_ptr_q - rd_ptr_q;
        occ      = {1'b0, mem_cnt} + (AW+2)'(out_vld_q);
        admit    = (occ <= ADMIT_MAX);
        rd_en    = (mem_cnt != '0) && (!out_vld_q || m_axis_tready);
        wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
        if (rd_en)
            out_vld_d = 1'b1;
        else if (m_axis_tready)
            out_vld_d = 1'b0;
        else
            out_vld_d = out_vld_q;
    end

`ifdef ADC_TEST_PATTERN_EN
    logic        from_idle;
    logic [13:0] ramp_q, ramp_d, ramp_cur;
`endif

    // frame sequencing: admission at each frame start, then count FRAME_LEN samples.
    // cnt_q==0 outside IDLE means a frame just ended and the next sample starts a new one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_last = 1'b0;
`ifdef ADC_TEST_PATTERN_EN
        from_idle = 1'b0;
`endif
        if (in_vld_q) begin
            if (state_q == IDLE || cnt_q == '0) begin
                if (!in_en_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = CW'(1);
                    if (admit) begin
                        state_d = CAPTURE;
                        wr_en   = 1'b1;
`ifdef ADC_TEST_PATTERN_EN
                        from_idle = (state_q == IDLE);
`endif
                    end else begin
                        state_d = SKIP;
                        ovf_d   = 1'b1;
                    end
                end
            end else begin
                wr_en = (state_q == CAPTURE);
                if (cnt_q == LAST_IDX) begin
                    wr_last = 1'b1;
                    cnt_d   = '0;
                    if (!in_en_q)
                        state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // FSM state, word counter and skip flag
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef ADC_TEST_PATTERN_EN
    // ramp restarts at 0 on each fresh capture from IDLE and advances per valid sample
    always_comb begin
        ramp_cur = from_idle ? 14'd0 : ramp_q;
        ramp_d   = in_vld_q ? ramp_cur + 14'd1 : ramp_q;
        smp_a    = ramp_cur;
        smp_b    = ~ramp_cur;
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst)
            ramp_q <= '0;
        else
            ramp_q <= ramp_d;
    end
`else
    // offset binary becomes two's complement by flipping the MSB
    always_comb begin
        smp_a = in_a_q ^ MSB_FLIP;
        smp_b = in_b_q ^ MSB_FLIP;
    end
`endif

    assign wr_word = {wr_last, {{2{smp_b[13]}}, smp_b}, {{2{smp_a[13]}}, smp_a}};

    // FIFO storage: no reset, contents are only meaningful between the pointers
    always_ff @(posedge adc_clk) begin
        if (wr_en)
            mem[wr_ptr_q[AW-1:0]] <= wr_word;
    end

    // registered RAM read feeds the stream output, held while the sink stalls
    always_ff @(posedge adc_clk) begin
        if (adc_rst)
            out_word_q <= '0;
        else if (rd_en)
            out_word_q <= mem[rd_ptr_q[AW-1:0]];
    end

    // FIFO pointers and output valid; reset flushes everything queued
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            out_vld_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            out_vld_q <= out_vld_d;
        end
    end

    // sticky overrange: a qualifying sample sets it, a data_en rising edge clears it
    always_comb begin
        en_prev_d = in_en_q;
        if (in_vld_q && in_en_q && in_or_q)
            or_d = 1'b1;
        else if (in_en_q && !en_prev_q)
            or_d = 1'b0;
        else
            or_d = or_q;
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            or_q      <= 1'b0;
            en_prev_q <= 1'b0;
        end else begin
            or_q      <= or_d;
            en_prev_q <= en_prev_d;
        end
    end

    assign adc_or_state  = or_q;
    assign ovf_sticky    = ovf_q;
    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tdata  = out_word_q[31:0];
    assign m_axis_tlast  = out_word_q[32];

endmodule
